// File: rtl/pcie_rx_pkg.sv
// Shared PCIe RX symbol, polynomial and sync-header constants, plus the
// scrambler mode decode used by the per-lane descrambler.
package pcie_rx_pkg;

    localparam logic [7:0]  COM_SYM    = 8'hBC;
    localparam logic [7:0]  SKP_SYM    = 8'h1C;
    localparam logic [15:0] GEN12_POLY = 16'h0039;
    localparam logic [22:0] GEN3_POLY  = 23'h210125;
    localparam logic [15:0] GEN12_SEED = 16'hFFFF;
    localparam logic [1:0]  SYNC_DATA  = 2'b10;
    localparam logic [1:0]  SYNC_OS    = 2'b01;

    typedef enum logic {
        MODE_GEN12 = 1'b0,
        MODE_GEN3  = 1'b1
    } scrMode_e;

    function automatic scrMode_e genToMode(input logic [2:0] gen);
        return (gen >= 3'd3) ? MODE_GEN3 : MODE_GEN12;
    endfunction

endpackage

// File: rtl/lfsr_byte_step.sv
// One byte of descrambling: decides whether the byte is descrambled, skipped or
// reseeds the LFSR, then runs the LFSR eight steps from bit 0 to bit 7.
module lfsr_byte_step
    import pcie_rx_pkg::*;
(
    input  scrMode_e    mode,
    input  logic        enable,
    input  logic [22:0] lfsrIn,
    input  logic [7:0]  dataIn,
    input  logic        dataK,
    input  logic [1:0]  syncHeader,
    output logic [7:0]  dataOut,
    output logic [22:0] lfsrOut
);

    logic advance;
    logic scramble;
    logic reseed;
    logic fb;

    always_comb begin
        advance  = 1'b0;
        scramble = 1'b0;
        reseed   = 1'b0;
        if (enable) begin
            if (mode == MODE_GEN12) begin
                if (dataK) begin
                    if (dataIn == COM_SYM) begin
                        reseed = 1'b1;
                    end else if (dataIn != SKP_SYM) begin
                        advance = 1'b1;
                    end
                end else begin
                    advance  = 1'b1;
                    scramble = 1'b1;
                end
            end else if (syncHeader == SYNC_DATA) begin
                advance  = 1'b1;
                scramble = 1'b1;
            end
        end
    end

    // Gen1/2 keeps the upper seven state bits cleared; Gen3+ uses all 23.
    always_comb begin
        lfsrOut = lfsrIn;
        dataOut = dataIn;
        fb      = 1'b0;
        if (reseed) begin
            lfsrOut = {7'b0, GEN12_SEED};
        end else if (advance) begin
            for (int unsigned i = 0; i < 8; i++) begin
                fb = (mode == MODE_GEN12) ? lfsrOut[15] : lfsrOut[22];
                if (scramble) begin
                    dataOut[i] = dataIn[i] ^ fb;
                end
                if (mode == MODE_GEN12) begin
                    lfsrOut = {7'b0, lfsrOut[14:0], 1'b0} ^ (fb ? {7'b0, GEN12_POLY} : '0);
                end else begin
                    lfsrOut = {lfsrOut[21:0], 1'b0} ^ (fb ? GEN3_POLY : '0);
                end
            end
        end
    end

endmodule

// File: rtl/descrambler_lane.sv
// Per-lane PIPE RX descrambler: four chained byte steps over one shared LFSR,
// registered outputs one cycle after each valid word.
module descrambler_lane
    import pcie_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  GEN,
    input  logic        turnOff,
    input  logic        PIPEDataValid,
    input  logic [5:0]  PIPEWIDTH,
    input  logic [1:0]  PIPESyncHeader,
    input  logic [23:0] seedValue,
    input  logic [31:0] PIPEData,
    input  logic [3:0]  PIPEDataK,
    output logic        descramblerDataValid,
    output logic [31:0] descramblerData,
    output logic [3:0]  descramblerDataK,
    output logic [1:0]  descramblerSyncHeader
);

    scrMode_e    mode;
    logic [22:0] lfsrQ;
    logic [22:0] lfsrChain [0:4];
    logic [7:0]  byteOut [0:3];
    logic [3:0]  byteActive;
    logic [31:0] descrambled;
    logic        unusedSeedMsb;

    assign mode          = genToMode(GEN);
    assign lfsrChain[0]  = lfsrQ;
    assign unusedSeedMsb = seedValue[23];

    for (genvar b = 0; b < 4; b++) begin : gByte
        assign byteActive[b] = (PIPEWIDTH > 6'(8 * b));

        lfsr_byte_step uStep (
            .mode       (mode),
            .enable     (byteActive[b] && PIPEDataValid && !turnOff),
            .lfsrIn     (lfsrChain[b]),
            .dataIn     (PIPEData[8*b +: 8]),
            .dataK      (PIPEDataK[b]),
            .syncHeader (PIPESyncHeader),
            .dataOut    (byteOut[b]),
            .lfsrOut    (lfsrChain[b+1])
        );
    end

    always_comb begin
        descrambled = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (byteActive[b]) begin
                descrambled[8*b +: 8] = byteOut[b];
            end
        end
    end

    // Bytes beyond the active width do not advance the LFSR, so the last chain
    // tap is always the correct next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsrQ                 <= (mode == MODE_GEN3) ? seedValue[22:0] : {7'b0, GEN12_SEED};
            descramblerDataValid  <= 1'b0;
            descramblerData       <= '0;
            descramblerDataK      <= '0;
            descramblerSyncHeader <= '0;
        end else begin
            descramblerDataValid <= PIPEDataValid;
            if (PIPEDataValid) begin
                descramblerDataK      <= PIPEDataK;
                descramblerSyncHeader <= PIPESyncHeader;
                if (turnOff) begin
                    descramblerData <= PIPEData;
                end else begin
                    descramblerData <= descrambled;
                    lfsrQ           <= lfsrChain[4];
                end
            end
        end
    end

endmodule

// File: tb/tb_descrambler_lane.sv
// Directed, table-driven bench for descrambler_lane with hand-computed keystreams.
module tb_descrambler_lane;
    import pcie_rx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  GEN;
    logic        turnOff;
    logic        PIPEDataValid;
    logic [5:0]  PIPEWIDTH;
    logic [1:0]  PIPESyncHeader;
    logic [23:0] seedValue;
    logic [31:0] PIPEData;
    logic [3:0]  PIPEDataK;
    logic        descramblerDataValid;
    logic [31:0] descramblerData;
    logic [3:0]  descramblerDataK;
    logic [1:0]  descramblerSyncHeader;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        logic [2:0]  gen;
        bit          off;
        bit          vld;
        logic [5:0]  width;
        logic [1:0]  sync;
        logic [23:0] seed;
        logic [31:0] data;
        logic [3:0]  k;
        bit          eValid;
        logic [31:0] eData;
        logic [3:0]  eK;
        logic [1:0]  eSync;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    descrambler_lane dut (
        .clk                   (clk),
        .reset                 (reset),
        .GEN                   (GEN),
        .turnOff               (turnOff),
        .PIPEDataValid         (PIPEDataValid),
        .PIPEWIDTH             (PIPEWIDTH),
        .PIPESyncHeader        (PIPESyncHeader),
        .seedValue             (seedValue),
        .PIPEData              (PIPEData),
        .PIPEDataK             (PIPEDataK),
        .descramblerDataValid  (descramblerDataValid),
        .descramblerData       (descramblerData),
        .descramblerDataK      (descramblerDataK),
        .descramblerSyncHeader (descramblerSyncHeader)
    );

    function automatic vec_t mk(bit rst, logic [2:0] gen, bit off, bit vld, logic [5:0] w,
                                logic [1:0] sy, logic [23:0] sd, logic [31:0] d, logic [3:0] k,
                                bit ev, logic [31:0] ed, logic [3:0] ek, logic [1:0] es);
        vec_t v;
        v.rst = rst; v.gen = gen; v.off = off; v.vld = vld; v.width = w; v.sync = sy;
        v.seed = sd; v.data = d; v.k = k;
        v.eValid = ev; v.eData = ed; v.eK = ek; v.eSync = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v, input string tag);
        reset          = v.rst;
        GEN            = v.gen;
        turnOff        = v.off;
        PIPEDataValid  = v.vld;
        PIPEWIDTH      = v.width;
        PIPESyncHeader = v.sync;
        seedValue      = v.seed;
        PIPEData       = v.data;
        PIPEDataK      = v.k;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(descramblerDataValid), 32'(v.eValid));
        chk({tag, ".data"},  descramblerData, v.eData);
        chk({tag, ".k"},     32'(descramblerDataK), 32'(v.eK));
        chk({tag, ".sync"},  32'(descramblerSyncHeader), 32'(v.eSync));
    endtask

    initial begin
        // Gen1/2 stream: COM reseed, keystream FF 17 C0 14 B2 E7 02
        vecs.push_back(mk(1, 1, 0, 1,  8, 0, 24'h0, 32'h12345678, 4'h0, 0, 32'h0,        4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  8, 0, 24'h0, 32'h000000BC, 4'h1, 1, 32'h000000BC, 4'h1, 0));
        vecs.push_back(mk(0, 1, 0, 1,  8, 0, 24'h0, 32'h00000000, 4'h0, 1, 32'h000000FF, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  8, 0, 24'h0, 32'h00000000, 4'h0, 1, 32'h00000017, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  8, 0, 24'h0, 32'h00000000, 4'h0, 1, 32'h000000C0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  8, 3, 24'h0, 32'h000000AA, 4'hF, 0, 32'h000000C0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  8, 0, 24'h0, 32'h00000000, 4'h0, 1, 32'h00000014, 4'h0, 0));
        // COM in byte 0, non-COM K byte advances without descrambling
        vecs.push_back(mk(0, 1, 0, 1, 32, 0, 24'h0, 32'h00FB00BC, 4'h5, 1, 32'hC0FBFFBC, 4'h5, 0));
        vecs.push_back(mk(0, 1, 0, 1,  8, 0, 24'h0, 32'h00000000, 4'h0, 1, 32'h00000014, 4'h0, 0));
        // SKP holds, trailing COM reseeds for the following word
        vecs.push_back(mk(0, 1, 0, 1, 32, 0, 24'h0, 32'hBC1C0000, 4'hC, 1, 32'hBC1CE7B2, 4'hC, 0));
        vecs.push_back(mk(0, 1, 0, 1, 32, 0, 24'h0, 32'h00000000, 4'h0, 1, 32'h14C017FF, 4'h0, 0));
        // Bypass holds the LFSR
        vecs.push_back(mk(0, 1, 1, 1, 32, 0, 24'h0, 32'h11223344, 4'hA, 1, 32'h11223344, 4'hA, 0));
        vecs.push_back(mk(0, 1, 0, 1,  8, 0, 24'h0, 32'h00000000, 4'h0, 1, 32'h000000B2, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 16, 0, 24'h0, 32'h00000000, 4'h0, 1, 32'h000002E7, 4'h0, 0));
        // Mid-stream reset discards the word and reseeds
        vecs.push_back(mk(1, 1, 0, 1, 32, 2, 24'hABCDEF, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 1,  8, 0, 24'hABCDEF, 32'h00000000, 4'h0, 1, 32'h000000FF, 4'h0, 0));
        // Gen3+: zero seed, then seed 1 with ordered sets before data
        vecs.push_back(mk(1, 3, 0, 0, 32, 0, 24'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 32, SYNC_DATA, 24'h0, 32'hDEADBEEF, 4'hF, 1, 32'hDEADBEEF, 4'hF, SYNC_DATA));
        vecs.push_back(mk(1, 4, 0, 1, 32, SYNC_DATA, 24'h000001, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4, 0, 1, 32, SYNC_OS, 24'h000001, 32'h12345678, 4'h0, 1, 32'h12345678, 4'h0, SYNC_OS));
        vecs.push_back(mk(0, 5, 0, 1, 32, 2'b11, 24'h000001, 32'h00000000, 4'h0, 1, 32'h00000000, 4'h0, 2'b11));
        vecs.push_back(mk(0, 3, 0, 1, 32, SYNC_DATA, 24'h000001, 32'h00000000, 4'h0, 1, 32'h75400000, 4'h0, SYNC_DATA));

        foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

        // COM in byte 1 reseeds for later bytes, carried into the next word
        runVec(mk(1, 2, 0, 0,  8, 0, 24'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0), "comMid.rst");
        runVec(mk(0, 2, 0, 1, 16, 0, 24'h0, 32'h0000BC00, 4'h2, 1, 32'h0000BCFF, 4'h2, 0), "comMid.w0");
        runVec(mk(0, 2, 0, 1,  8, 0, 24'h0, 32'h00000000, 4'h0, 1, 32'h000000FF, 4'h0, 0), "comMid.w1");

        // GEN change without reset: Gen3 stepping continues from state 16'hFFFF
        runVec(mk(1, 1, 0, 0,  8, 0, 24'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0), "genChg.rst");
        runVec(mk(0, 3, 0, 1,  8, SYNC_DATA, 24'h0, 32'h00000000, 4'h0, 1, 32'h00000080, 4'h0, SYNC_DATA), "genChg.w0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
